onehot_way_sel: RTL

//  Registered, parametrised binary-to-one-hot selector with valid/ready handshake.
//  Two modes:
//   - DECODE: plain index-to-one-hot decode.
//   - VICTIM: cache/TLB way-victim select, first invalid way else round-robin.

---
 rtl/onehot_way_sel_pkg.sv | 13 +
 rtl/onehot_way_sel_ffz_lsb.sv | 25 ++
 rtl/onehot_way_sel.sv | 100 ++++++++++
 3 files changed

// File: rtl/onehot_way_sel_pkg.sv
// Shared definitions for the one-hot way selector: mode encodings and width limits.
// Both request modes share one output register stage.
package onehot_way_sel_pkg;

    typedef enum logic {
        SEL_DECODE = 1'b0,
        SEL_VICTIM = 1'b1
    } sel_mode_e;

    localparam int IDX_W_MIN = 1;
    localparam int IDX_W_MAX = 4;

endpackage

// File: rtl/onehot_way_sel_ffz_lsb.sv
// Find-first-zero over a per-way valid vector, lowest index wins.
// `found` is low only when every way is valid.
module ffz_lsb #(
    parameter int IDX_W = 2
) (
    input  logic [(1<<IDX_W)-1:0] vec,
    output logic [IDX_W-1:0]      idx,
    output logic                  found
);

    localparam int NWAY = 1 << IDX_W;

    // Scan from the top down so the last hit, the lowest index, sticks.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NWAY - 1; i >= 0; i--) begin
            if (!vec[i]) begin
                idx   = i[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_way_sel.sv
// Registered binary-to-one-hot selector with valid/ready handshake.
// DECODE mode passes the index through; VICTIM mode picks the first invalid way, else round-robin.
module onehot_way_sel
    import onehot_way_sel_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_idx,
    input  logic [(1<<IDX_W)-1:0] way_vld,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [(1<<IDX_W)-1:0] out_onehot,
    output logic [IDX_W-1:0]      out_idx
);

    localparam int NWAY = 1 << IDX_W;

    logic             out_valid_q,  out_valid_d;
    logic [NWAY-1:0]  out_onehot_q, out_onehot_d;
    logic [IDX_W-1:0] out_idx_q,    out_idx_d;
    logic [IDX_W-1:0] rr_ptr_q,     rr_ptr_d;

    logic [IDX_W-1:0] ffz_idx;
    logic             ffz_found;
    logic             accept;
    logic             victim_mode;
    logic [IDX_W-1:0] sel_idx;
    logic [NWAY-1:0]  sel_onehot;

    ffz_lsb #(
        .IDX_W (IDX_W)
    ) u_ffz (
        .vec   (way_vld),
        .idx   (ffz_idx),
        .found (ffz_found)
    );

    // Ready depends only on the output stage and flush, never on the request itself.
    assign in_ready    = (~out_valid_q | out_ready) & ~flush;
    assign accept      = in_valid & in_ready;
    assign victim_mode = (mode == SEL_VICTIM);

    always_comb begin
        sel_idx = in_idx;
        if (victim_mode) begin
            sel_idx = ffz_found ? ffz_idx : rr_ptr_q;
        end
        sel_onehot = {{(NWAY-1){1'b0}}, 1'b1} << sel_idx;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_onehot_d = out_onehot_q;
        out_idx_d    = out_idx_q;
        rr_ptr_d     = rr_ptr_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            out_onehot_d = '0;
            out_idx_d    = '0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_onehot_d = sel_onehot;
            out_idx_d    = sel_idx;
            // Pointer only advances when a full set forces a round-robin choice.
            if (victim_mode && !ffz_found) begin
                rr_ptr_d = rr_ptr_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
            out_onehot_d = '0;
            out_idx_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q  <= 1'b0;
            out_onehot_q <= '0;
            out_idx_q    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            out_idx_q    <= out_idx_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_idx    = out_idx_q;

endmodule
